stopwatch_counter: RTL

- Timekeeping core directly downstream of the clock-divider block. Consumes its CLK_1HZ and CLK_2HZ outputs as level signals, edge-detects them in the CLK_REF domain, and maintains a MM:SS BCD count.
- Supports run/pause and a manual adjust mode. The four BCD digits feed the 7-segment display stage.

---
 rtl/stopwatch_counter.sv | 84 ++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD stopwatch ticked by edge-detected 1 Hz / 2 Hz divider levels, with run/pause and adjust.
module stopwatch_counter #(
    parameter bit RUN_AT_RESET = 1'b1,
    parameter bit MIN_WRAP     = 1'b1
) (
    input  logic       CLK_REF,
    input  logic       RST,
    input  logic       CLK_1HZ,
    input  logic       CLK_2HZ,
    input  logic       PAUSE,
    input  logic       ADJ,
    input  logic       SEL,
    output logic [3:0] MIN_TENS,
    output logic [3:0] MIN_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] SEC_ONES,
    output logic       RUNNING
);
    // Synchroniser chains hold {s3, s2, s1}; reset to ones so a level held high through reset never ticks.
    logic [2:0] sync_1hz_q, sync_2hz_q;
    logic       pause_q, running_q;
    logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic [3:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic       tick_1hz, tick_2hz, pause_edge, running_d;
    logic       so_wrap, st_wrap, mo_wrap, mt_wrap, at_max, count_en, sec_inc, min_inc;

    assign tick_1hz   = sync_1hz_q[1] & ~sync_1hz_q[2];
    assign tick_2hz   = sync_2hz_q[1] & ~sync_2hz_q[2];
    assign pause_edge = PAUSE & ~pause_q;
    assign running_d  = running_q ^ pause_edge;

    assign so_wrap  = sec_ones_q >= 4'd9;
    assign st_wrap  = sec_tens_q >= 4'd5;
    assign mo_wrap  = min_ones_q >= 4'd9;
    assign mt_wrap  = min_tens_q >= 4'd9;
    assign at_max   = so_wrap & st_wrap & mo_wrap & mt_wrap;
    // Counting uses the pre-toggle running flag; saturation blocks the whole increment.
    assign count_en = tick_1hz & running_q & ~ADJ & ~(at_max & ~MIN_WRAP);
    assign sec_inc  = count_en | (tick_2hz & ADJ & SEL);
    assign min_inc  = (count_en & so_wrap & st_wrap) | (tick_2hz & ADJ & ~SEL);

    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        if (sec_inc) begin
            sec_ones_d = so_wrap ? 4'd0 : sec_ones_q + 4'd1;
            sec_tens_d = so_wrap ? (st_wrap ? 4'd0 : sec_tens_q + 4'd1) : sec_tens_q;
        end
        if (min_inc) begin
            min_ones_d = mo_wrap ? 4'd0 : min_ones_q + 4'd1;
            min_tens_d = mo_wrap ? (mt_wrap ? 4'd0 : min_tens_q + 4'd1) : min_tens_q;
        end
    end

    always_ff @(posedge CLK_REF) begin
        if (RST) begin
            sync_1hz_q <= 3'b111;
            sync_2hz_q <= 3'b111;
            pause_q    <= 1'b1;
            running_q  <= RUN_AT_RESET;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
        end else begin
            sync_1hz_q <= {sync_1hz_q[1:0], CLK_1HZ};
            sync_2hz_q <= {sync_2hz_q[1:0], CLK_2HZ};
            pause_q    <= PAUSE;
            running_q  <= running_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
        end
    end

    assign MIN_TENS = min_tens_q;
    assign MIN_ONES = min_ones_q;
    assign SEC_TENS = sec_tens_q;
    assign SEC_ONES = sec_ones_q;
    assign RUNNING  = running_q;
endmodule
